// File: rtl/binary16_accum_seq.sv
// Sequential binary16 vector accumulator. Elements are summed through an
// external pipelined binary16 adder; the block itself only tests for zero.
module binary16_accum_seq #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic [15:0]        in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [15:0]        add_a,
  output logic [15:0]        add_b,
  output logic               add_valid,
  input  logic [15:0]        add_result,
  input  logic               add_result_valid,
  output logic [15:0]        sum_out,
  output logic               sum_valid,
  output logic [COUNT_W-1:0] sum_count,
  output logic               err_timeout
);

  localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ADD_WAIT = 2'd1;
  localparam logic [1:0] EMIT     = 2'd2;

  logic [1:0]         state;
  logic [15:0]        acc;
  logic               acc_zero;
  logic [COUNT_W-1:0] count;
  logic [TIMER_W-1:0] timer;
  logic               last_q;
  logic [15:0]        sum_out_q;
  logic [COUNT_W-1:0] sum_count_q;

  logic accept;
  logic elem_zero;
  logic result_zero;

  // Handshake and zero tests; in_ready is forced low while reset is held.
  always_comb begin
    in_ready    = (state == IDLE) && !rst;
    accept      = in_valid && in_ready;
    elem_zero   = (in_data[14:10] == 5'd0);
    result_zero = (add_result[14:10] == 5'd0);
  end

  // Sum outputs are live during EMIT and hold their last value otherwise.
  always_comb begin
    sum_valid = (state == EMIT);
    sum_out   = sum_out_q;
    sum_count = sum_count_q;
    if (state == EMIT) begin
      sum_out   = acc_zero ? 16'h0000 : acc;
      sum_count = count;
    end
  end

  // FSM, accumulator, counters and adder interface registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= 16'h0000;
      acc_zero    <= 1'b1;
      count       <= '0;
      timer       <= '0;
      last_q      <= 1'b0;
      add_a       <= 16'h0000;
      add_b       <= 16'h0000;
      add_valid   <= 1'b0;
      sum_out_q   <= 16'h0000;
      sum_count_q <= '0;
      err_timeout <= 1'b0;
    end else begin
      add_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (count != '1) count <= count + 1'b1;
            if (elem_zero) begin
              if (in_last) state <= EMIT;
            end else if (acc_zero) begin
              // First nonzero element needs no add.
              acc      <= in_data;
              acc_zero <= 1'b0;
              if (in_last) state <= EMIT;
            end else begin
              add_a     <= acc;
              add_b     <= in_data;
              add_valid <= 1'b1;
              last_q    <= in_last;
              timer     <= '0;
              state     <= ADD_WAIT;
            end
          end
        end
        ADD_WAIT: begin
          if (add_result_valid) begin
            // Subnormal or zero results are flushed to zero.
            if (result_zero) begin
              acc      <= 16'h0000;
              acc_zero <= 1'b1;
            end else begin
              acc <= add_result;
            end
            state <= last_q ? EMIT : IDLE;
          end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= last_q ? EMIT : IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        EMIT: begin
          sum_out_q   <= sum_out;
          sum_count_q <= count;
          count       <= '0;
          acc         <= 16'h0000;
          acc_zero    <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_binary16_accum_seq.sv
// Directed testbench for binary16_accum_seq with a 4-stage model adder.
module tb_binary16_accum_seq;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = 16'h0000;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_valid;
  logic [15:0] add_result;
  logic        add_result_valid;
  logic [15:0] sum_out;
  logic        sum_valid;
  logic [7:0]  sum_count;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;
  int add_cnt = 0;
  int sum_cnt = 0;
  logic model_en = 1'b1;

  logic [3:0]  pv = 4'b0000;
  logic [15:0] pd [4];

  binary16_accum_seq #(.TIMEOUT(15), .COUNT_W(8)) dut (
    .clk_in           (clk_in),
    .rst              (rst),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_last          (in_last),
    .in_ready         (in_ready),
    .add_a            (add_a),
    .add_b            (add_b),
    .add_valid        (add_valid),
    .add_result       (add_result),
    .add_result_valid (add_result_valid),
    .sum_out          (sum_out),
    .sum_valid        (sum_valid),
    .sum_count        (sum_count),
    .err_timeout      (err_timeout)
  );

  always #5 clk_in = ~clk_in;

  // Hand-computed binary16 sums for the operand pairs used here.
  function automatic logic [15:0] f16_add(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h3C00 && b == 16'h4000) return 16'h4200;
    if (a == 16'h3C00 && b == 16'h3C00) return 16'h4000;
    if (a == 16'h4000 && b == 16'h4000) return 16'h4400;
    return 16'h0000;
  endfunction

  // Model adder: 4 pipeline stages, not affected by the DUT reset.
  always @(posedge clk_in) begin
    pv[0] <= add_valid && model_en;
    pd[0] <= f16_add(add_a, add_b);
    for (int i = 1; i < 4; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end
  assign add_result       = pd[3];
  assign add_result_valid = pv[3];

  // Strobe counters sampled mid-cycle.
  always @(negedge clk_in) begin
    if (add_valid) add_cnt++;
    if (sum_valid) sum_cnt++;
  end

  // Present one element at a negedge, wait for in_ready, let the next posedge accept it.
  task automatic send(input logic [15:0] d, input logic l, input logic keep);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL send_ready: in_ready stayed %0b, required 1", in_ready);
    end
    @(negedge clk_in);
    if (!keep) in_valid = 1'b0;
  endtask

  // Count negedges until sum_valid is seen, bounded.
  task automatic wait_sum(output int cycles);
    cycles = 0;
    while (!sum_valid && cycles < 60) begin
      @(negedge clk_in);
      cycles++;
    end
    checks++;
    if (!sum_valid) begin
      errors++;
      $display("FAIL wait_sum: sum_valid=%0b after %0d cycles, required 1", sum_valid, cycles);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({in_ready, add_valid, sum_valid, err_timeout} !== 4'b0000 || add_a !== 16'h0 ||
        add_b !== 16'h0 || sum_out !== 16'h0 || sum_count !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%0b av=%0b sv=%0b err=%0b a=%h b=%h s=%h c=%0d, required all 0",
               in_ready, add_valid, sum_valid, err_timeout, add_a, add_b, sum_out, sum_count);
    end
    @(negedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%0b, required 1", in_ready);
    end
  endtask

  task automatic test_two_add();
    int cyc;
    int a0;
    a0 = add_cnt;
    send(16'h3C00, 1'b0, 1'b0);
    send(16'h4000, 1'b1, 1'b0);
    checks++;
    if (add_valid !== 1'b1 || add_a !== 16'h3C00 || add_b !== 16'h4000) begin
      errors++;
      $display("FAIL two_add_issue: av=%0b a=%h b=%h, required 1 3c00 4000", add_valid, add_a, add_b);
    end
    wait_sum(cyc);
    checks++;
    if (cyc != 5) begin
      errors++;
      $display("FAIL two_add_latency: %0d cycles, required 5", cyc);
    end
    checks++;
    if (sum_out !== 16'h4200 || sum_count !== 8'd2) begin
      errors++;
      $display("FAIL two_add_sum: sum=%h cnt=%0d, required 4200 2", sum_out, sum_count);
    end
    checks++;
    if (add_cnt - a0 != 1) begin
      errors++;
      $display("FAIL two_add_count: %0d add strobes, required 1", add_cnt - a0);
    end
    @(negedge clk_in);
    checks++;
    if (sum_valid !== 1'b0 || sum_out !== 16'h4200 || sum_count !== 8'd2) begin
      errors++;
      $display("FAIL two_add_hold: sv=%0b sum=%h cnt=%0d, required 0 4200 2",
               sum_valid, sum_out, sum_count);
    end
  endtask

  task automatic test_single();
    int cyc;
    int a0;
    a0 = add_cnt;
    send(16'h3C00, 1'b1, 1'b0);
    wait_sum(cyc);
    checks++;
    if (cyc != 0 || sum_out !== 16'h3C00 || sum_count !== 8'd1 || add_cnt != a0) begin
      errors++;
      $display("FAIL single: cyc=%0d sum=%h cnt=%0d adds=%0d, required 0 3c00 1 0",
               cyc, sum_out, sum_count, add_cnt - a0);
    end
    @(negedge clk_in);
  endtask

  task automatic test_zeros();
    int cyc;
    int a0;
    a0 = add_cnt;
    send(16'h0000, 1'b0, 1'b0);
    send(16'h0000, 1'b1, 1'b0);
    wait_sum(cyc);
    checks++;
    if (cyc != 0 || sum_out !== 16'h0000 || sum_count !== 8'd2 || add_cnt != a0) begin
      errors++;
      $display("FAIL zeros: cyc=%0d sum=%h cnt=%0d adds=%0d, required 0 0000 2 0",
               cyc, sum_out, sum_count, add_cnt - a0);
    end
    @(negedge clk_in);
  endtask

  task automatic test_timeout();
    int cyc;
    model_en = 1'b0;
    send(16'h3C00, 1'b0, 1'b0);
    send(16'h3C00, 1'b1, 1'b0);
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: err=%0b, required 0", err_timeout);
    end
    wait_sum(cyc);
    checks++;
    if (cyc != 15 || err_timeout !== 1'b1 || sum_out !== 16'h3C00 || sum_count !== 8'd2) begin
      errors++;
      $display("FAIL timeout: cyc=%0d err=%0b sum=%h cnt=%0d, required 15 1 3c00 2",
               cyc, err_timeout, sum_out, sum_count);
    end
    @(negedge clk_in);
    model_en = 1'b1;
    send(16'h3C00, 1'b1, 1'b0);
    wait_sum(cyc);
    checks++;
    if (err_timeout !== 1'b1 || sum_out !== 16'h3C00 || sum_count !== 8'd1) begin
      errors++;
      $display("FAIL timeout_sticky: err=%0b sum=%h cnt=%0d, required 1 3c00 1",
               err_timeout, sum_out, sum_count);
    end
    @(negedge clk_in);
  endtask

  task automatic test_reset_in_wait();
    int s0;
    int bad;
    send(16'h3C00, 1'b0, 1'b0);
    send(16'h3C00, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || add_valid !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL midreset_assert: rdy=%0b av=%0b err=%0b, required 0 0 0",
               in_ready, add_valid, err_timeout);
    end
    @(negedge clk_in);
    rst = 1'b0;
    s0 = sum_cnt;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: in_ready=%0b, required 1", in_ready);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      #1;
      if (sum_valid !== 1'b0 || add_valid !== 1'b0 || sum_out !== 16'h0 ||
          sum_count !== 8'h0 || add_a !== 16'h0 || add_b !== 16'h0 ||
          err_timeout !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || sum_cnt != s0) begin
      errors++;
      $display("FAIL midreset_quiet: %0d bad cycles, %0d sums, required 0 0", bad, sum_cnt - s0);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    send(16'h3C00, 1'b0, 1'b1);
    send(16'h3C00, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_wait1: in_ready=%0b, required 0", in_ready);
    end
    send(16'h4000, 1'b1, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_wait2: in_ready=%0b, required 0", in_ready);
    end
    wait_sum(cyc);
    checks++;
    if (sum_out !== 16'h4400 || sum_count !== 8'd3) begin
      errors++;
      $display("FAIL b2b_sum: sum=%h cnt=%0d, required 4400 3", sum_out, sum_count);
    end
    @(negedge clk_in);
  endtask

  initial begin
    test_reset();
    test_two_add();
    test_single();
    test_zeros();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
